// File: rtl/bch_encoder_serial.sv
// Systematic BCH(15,7) t=2 encoder: bit-serial LFSR division of m(x)*x^8 by g(x),
// one message bit per clock, with valid/ready handshakes on both sides.
module bch_encoder_serial #(
    parameter logic [8:0] GEN_POLY = 9'h1D1,
    parameter int         MSG_W    = 7,
    parameter int         CW_W     = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MSG_W-1:0] in_msg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW_W-1:0]  codeword,
    output logic             busy
);
    localparam int         PAR_W = CW_W - MSG_W;
    localparam logic [2:0] LAST  = 3'(MSG_W - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t             state, state_nxt;
    logic [MSG_W-1:0]   msg_reg;
    logic [PAR_W-1:0]   lfsr, lfsr_nxt;
    logic [2:0]         cnt;
    logic               fb, accept;

    // MSB-first division: the message bit enters at the top of the register
    assign fb       = msg_reg[LAST - cnt] ^ lfsr[PAR_W-1];
    assign lfsr_nxt = {lfsr[PAR_W-2:0], 1'b0} ^ (fb ? GEN_POLY[PAR_W-1:0] : '0);
    assign accept   = in_valid & in_ready;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                if (cnt == LAST) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                // a new message may enter on the same edge the codeword leaves
                in_ready  = out_ready;
                if (out_ready) state_nxt = in_valid ? SHIFT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            msg_reg  <= '0;
            lfsr     <= '0;
            cnt      <= '0;
            codeword <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                msg_reg <= in_msg;
                lfsr    <= '0;
                cnt     <= '0;
            end else if (state == SHIFT) begin
                lfsr <= lfsr_nxt;
                cnt  <= (cnt == LAST) ? 3'd0 : cnt + 3'd1;
                if (cnt == LAST) codeword <= {msg_reg, lfsr_nxt};
            end
        end
    end

endmodule

// File: tb/tb_bch_encoder_serial.sv
// Scoreboard bench for bch_encoder_serial: expected codewords are queued on each
// accepted message and compared, with latency and nearest-codeword decode, on output.
module tb_bch_encoder_serial;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_msg = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [14:0] codeword;
    logic        busy;

    bch_encoder_serial dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_msg(in_msg),
        .out_valid(out_valid), .out_ready(out_ready), .codeword(codeword),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // reference: long division of m(x)*x^8 by g(x)
    function automatic logic [14:0] enc(input logic [6:0] m);
        logic [14:0] r;
        r = {m, 8'h00};
        for (int i = 14; i >= 8; i--)
            if (r[i]) r = r ^ (15'h01D1 << (i - 8));
        return {m, r[7:0]};
    endfunction

    function automatic logic [7:0] rem(input logic [14:0] c);
        logic [14:0] r;
        r = c;
        for (int i = 14; i >= 8; i--)
            if (r[i]) r = r ^ (15'h01D1 << (i - 8));
        return r[7:0];
    endfunction

    function automatic logic [6:0] nearest(input logic [14:0] w);
        int best_d;
        logic [6:0] best_m;
        best_d = 99;
        best_m = '0;
        for (int m = 0; m < 128; m++) begin
            int d;
            d = $countones(w ^ enc(7'(m)));
            if (d < best_d) begin best_d = d; best_m = 7'(m); end
        end
        return best_m;
    endfunction

    logic [14:0] exp_q[$];
    int          acc_q[$];
    bit          shown = 0;
    int          last_valid_cyc = 0, prev_valid_cyc = 0;

    // monitor at negedge: inputs change only just after posedge
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            acc_q.delete();
            shown = 0;
        end else begin
            if (out_valid && !shown) begin
                shown = 1;
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
                if (acc_q.size() > 0) check("latency", cyc - acc_q.pop_front(), 8);
                else check("spurious_valid", 1, 0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("unexpected_cw", {17'h0, codeword}, 32'hFFFF);
                else begin
                    logic [14:0] e, w;
                    int i, j;
                    e = exp_q.pop_front();
                    check("codeword", codeword, e);
                    check("cw_remainder", rem(codeword), 0);
                    i = $urandom_range(0, 14);
                    j = $urandom_range(0, 14);
                    w = codeword ^ (15'h1 << i) ^ (15'h1 << j);
                    check("decode_2err", nearest(w), e[14:8]);
                end
                shown = 0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(enc(in_msg));
                acc_q.push_back(cyc);
            end
        end
    end

    task automatic send(input logic [6:0] m);
        bit ok, rdy;
        ok = 0;
        in_valid = 1'b1;
        in_msg   = m;
        for (int k = 0; k < 100 && !ok; k++) begin
            #1 rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1;
        end
        in_valid = 1'b0;
        in_msg   = 7'($urandom);
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            if (out_valid) ok = 1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) check("valid_timeout", 0, 1);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !out_valid) ok = 1;
        end
        if (!ok) check("drain_timeout", 0, 1);
    endtask

    task automatic expect_cw(input logic [6:0] m, input logic [14:0] lit);
        send(m);
        wait_valid();
        check("cw_literal", codeword, lit);
        drain();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_codeword", codeword, 0);

        out_ready = 1'b1;
        expect_cw(7'h00, 15'h0000);
        expect_cw(7'h01, 15'h01D1);
        expect_cw(7'h40, 15'h40E8);
        expect_cw(7'h7F, 15'h7FFF);

        // stall in HOLD with in_valid pressed and in_msg changing
        out_ready = 1'b0;
        send(7'h55);
        wait_valid();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_msg   = 7'($urandom);
            #1;
            check("stall_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_cw", codeword, enc(7'h55));
            check("stall_busy", busy, 1);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // back-to-back
        send(7'h01);
        send(7'h40);
        drain();
        check("b2b_spacing", last_valid_cyc - prev_valid_cyc, 8);

        // reset mid-SHIFT at cnt=3
        send(7'h2A);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_codeword", codeword, 0);
        repeat (12) @(posedge clk);
        #1;

        // every message, with random idle gaps
        for (int m = 0; m < 128; m++) begin
            send(7'(m));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
